// File: rtl/sub16_pkg.sv
// Shared types and constants for the pipelined saturating 16-bit subtractor.
package sub16_pkg;

  localparam int DATA_W = 16;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

  // Operands captured in the first stage, with their saturation enable.
  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic                     sat_en;
  } s1_t;

  // Result and raw overflow held in the output stage.
  typedef struct packed {
    logic signed [DATA_W-1:0] result;
    logic                     ovf;
  } s2_t;

  // Clamp an overflowed difference toward the sign of the minuend.
  // The wrapped difference passes through when saturation is off or
  // when there was no overflow.
  function automatic logic signed [DATA_W-1:0] sat_sel(
    input logic signed [DATA_W-1:0] diff,
    input logic                     a_msb,
    input logic                     ovf,
    input logic                     sat_en
  );
    logic signed [DATA_W-1:0] res;
    res = diff;
    if (sat_en && ovf) begin
      res = a_msb ? SAT_MIN : SAT_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/sub_16bit_signed.sv
// Combinational 16-bit signed subtractor with two's-complement overflow flag.
module sub_16bit_signed (
  input  logic signed [15:0] A,
  input  logic signed [15:0] B,
  output logic signed [15:0] result,
  output logic               overflow
);

  assign result   = A - B;
  // Overflow only when operand signs differ and the result sign leaves A's.
  assign overflow = (A[15] != B[15]) && (result[15] != A[15]);

endmodule

// File: rtl/sub_16bit_signed_sat_pipe.sv
// Two-stage valid/ready pipeline around sub_16bit_signed with optional
// per-operation saturation, a sticky overflow flag and a saturating
// overflow-event counter.
module sub_16bit_signed_sat_pipe
  import sub16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_overflow,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             adv1;
  logic             adv2;
  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  s2_t              s2_q, s2_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_xfer;

  logic signed [DATA_W-1:0] diff;
  logic                     sub_ovf;

  // A stage may take new data when it is empty or its content moves on.
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  // ---- Stage 1: capture operands ----
  // Next-state for the operand stage.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.a      = in_a;
        s1_d.b      = in_b;
        s1_d.sat_en = in_sat_en;
      end
    end
  end

  sub_16bit_signed u_sub (
    .A        (s1_q.a),
    .B        (s1_q.b),
    .result   (diff),
    .overflow (sub_ovf)
  );

  // ---- Stage 2: register result and overflow ----
  // Next-state for the output stage; data only moves when stage 1 is full.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.result = sat_sel(diff, s1_q.a[DATA_W-1], sub_ovf, s1_q.sat_en);
        s2_d.ovf    = sub_ovf;
      end
    end
  end

  // Status: a transferred overflow beats a simultaneous clear.
  assign ovf_xfer = s2_valid_q && out_ready && s2_q.ovf;

  // Next-state for the sticky flag and saturating event counter.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (ovf_xfer) begin
      sticky_d = 1'b1;
      if (clr_sticky) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  // Operand register; its contents are ignored while s1_valid_q is low.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  // Control, output stage and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_q.result;
  assign out_overflow = s2_q.ovf;
  assign sticky_ovf   = sticky_q;
  assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_sub_16bit_signed_sat_pipe.sv
// Bench for sub_16bit_signed_sat_pipe: a queue-based reference model plus
// directed literal checks, with two instances (default and 2-bit counter).
module tb_sub_16bit_signed_sat_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sat_en = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_sticky = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;

  logic        in_ready, out_valid, out_overflow, sticky_ovf;
  logic [15:0] out_result;
  logic [7:0]  ovf_count;

  logic        in_ready2, out_valid2, out_overflow2, sticky_ovf2;
  logic [15:0] out_result2;
  logic [1:0]  ovf_count2;

  always #5 clk = ~clk;

  sub_16bit_signed_sat_pipe #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sat_en(in_sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .sticky_ovf(sticky_ovf),
    .clr_sticky(clr_sticky), .ovf_count(ovf_count)
  );

  sub_16bit_signed_sat_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_sat_en(in_sat_en),
    .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
    .out_overflow(out_overflow2), .sticky_ovf(sticky_ovf2),
    .clr_sticky(clr_sticky), .ovf_count(ovf_count2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer difference, then range test and clamp.
  function automatic void ref_op(input logic [15:0] a, input logic [15:0] b,
                                 input logic sat, output logic [15:0] r,
                                 output logic o);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    o = (d > 32767) || (d < -32768);
    if (sat && o) r = (d > 0) ? 16'h7FFF : 16'h8000;
    else          r = 16'(d);
  endfunction

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          e;
  } item_t;

  item_t       q[$];
  logic [15:0] got_res[$];
  logic        got_ovf[$];
  int          got_e[$];
  int          edge_n = 0;
  int          n_ovf = 0;
  logic        sticky_m = 1'b0;
  logic [15:0] last_res = '0;
  logic        last_ovf = 1'b0;

  logic [15:0] EDGE [9] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000,
                            16'h7FFE, 16'h8001, 16'h4000, 16'hC000};

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Compare process: checks every output each cycle, then advances the model
  // by whatever transfers the coming edge will perform.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q.delete();
      n_ovf    = 0;
      sticky_m = 1'b0;
      last_res = '0;
      last_ovf = 1'b0;
    end else begin
      logic        exp_v;
      logic        xo;
      logic [15:0] r;
      logic        o;
      exp_v = (q.size() > 0) && (q[0].e < edge_n);
      if (exp_v) begin
        last_res = q[0].res;
        last_ovf = q[0].ovf;
      end
      chk("out_valid", out_valid, exp_v);
      chk("out_valid2", out_valid2, exp_v);
      chk("out_result", out_result, last_res);
      chk("out_result2", out_result2, last_res);
      chk("out_overflow", out_overflow, last_ovf);
      chk("out_overflow2", out_overflow2, last_ovf);
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      chk("in_ready2", in_ready2, !(q.size() == 2 && !out_ready));
      chk("sticky_ovf", sticky_ovf, sticky_m);
      chk("sticky_ovf2", sticky_ovf2, sticky_m);
      chk("ovf_count", ovf_count, (n_ovf > 255) ? 255 : n_ovf);
      chk("ovf_count2", ovf_count2, (n_ovf > 3) ? 3 : n_ovf);
      xo = 1'b0;
      if (exp_v && out_ready) begin
        got_res.push_back(q[0].res);
        got_ovf.push_back(q[0].ovf);
        got_e.push_back(edge_n + 1);
        xo = q[0].ovf;
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        ref_op(in_a, in_b, in_sat_en, r, o);
        q.push_back('{res: r, ovf: o, e: edge_n + 1});
      end
      if (xo) begin
        sticky_m = 1'b1;
        n_ovf    = clr_sticky ? 1 : n_ovf + 1;
      end else if (clr_sticky) begin
        sticky_m = 1'b0;
        n_ovf    = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    clr_sticky = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sat);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sat_en = sat;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || out_valid) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta [3];
    int tb [3];
    int idx;
    ta = '{5, 7, 9};
    tb = '{2, 3, 4};

    // 1: reset values and a plain subtraction with latency 2
    do_reset();
    out_ready = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_sticky", sticky_ovf, 0);
    chk("rst_count", ovf_count, 0);
    chk("rst_in_ready", in_ready, 1);
    send(16'd100, 16'd30, 1'b0);
    chk("t1_not_yet", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, 70);
    chk("t1_ovf", out_overflow, 0);
    chk("t1_sticky", sticky_ovf, 0);
    drain();

    // 2: overflow, wrap vs saturate, both directions
    got_res.delete(); got_ovf.delete(); got_e.delete();
    send(16'h7FFF, 16'hFFFF, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b1);
    send(16'h8000, 16'h0001, 1'b1);
    drain();
    chk("t2_n", got_res.size(), 3);
    chk("t2_wrap", got_res[0], 16'h8000);
    chk("t2_wrap_ovf", got_ovf[0], 1);
    chk("t2_satpos", got_res[1], 16'h7FFF);
    chk("t2_satpos_ovf", got_ovf[1], 1);
    chk("t2_satneg", got_res[2], 16'h8000);
    chk("t2_satneg_ovf", got_ovf[2], 1);
    chk("t2_sticky", sticky_ovf, 1);
    chk("t2_count", ovf_count, 3);

    // 3: all 81 boundary pairs back to back, one result per cycle
    got_res.delete(); got_ovf.delete(); got_e.delete();
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++)
        send(EDGE[i], EDGE[j], 1'((i + j) % 2));
    drain();
    chk("t3_n", got_res.size(), 81);
    for (int i = 1; i < got_e.size(); i++)
      chk("t3_rate", got_e[i] - got_e[0], i);

    // 4: stall with three pending ops; only two fit
    got_res.delete(); got_ovf.delete(); got_e.delete();
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_a = 16'(ta[idx]);
      in_b = 16'(tb[idx]);
      in_sat_en = 1'b0;
      @(negedge clk);
      if (in_ready) idx++;
      tick();
      if (idx > 2) idx = 2;
    end
    chk("t4_accepted", idx, 2);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_held_valid", out_valid, 1);
    chk("t4_held_result", out_result, 3);
    out_ready = 1'b1;
    send(16'd9, 16'd4, 1'b0);
    drain();
    chk("t4_n", got_res.size(), 3);
    chk("t4_r0", got_res[0], 3);
    chk("t4_r1", got_res[1], 4);
    chk("t4_r2", got_res[2], 5);

    // 5: counter saturation (2-bit instance) and clear priority
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(16'h7FFF, 16'hFFFF, 1'b1);
    drain();
    chk("t5_cnt2_sat", ovf_count2, 3);
    chk("t5_cnt8", ovf_count, 5);
    chk("t5_sticky", sticky_ovf2, 1);
    send(16'h8000, 16'h0001, 1'b0);
    tick();
    chk("t5_valid", out_valid, 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t5_clr_ovf_sticky", sticky_ovf, 1);
    chk("t5_clr_ovf_cnt2", ovf_count2, 1);
    chk("t5_clr_ovf_cnt8", ovf_count, 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t5_clr_sticky", sticky_ovf, 0);
    chk("t5_clr_cnt2", ovf_count2, 0);
    chk("t5_clr_cnt8", ovf_count, 0);

    // 6: asynchronous reset mid-cycle with two ops in flight
    send(16'h7FFF, 16'hFFFF, 1'b0);
    drain();
    out_ready = 1'b0;
    send(16'd5, 16'd2, 1'b0);
    send(16'd7, 16'd3, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_result", out_result, 0);
    chk("t6_ovf", out_overflow, 0);
    chk("t6_sticky", sticky_ovf, 0);
    chk("t6_count", ovf_count, 0);
    chk("t6_count2", ovf_count2, 0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    got_res.delete(); got_ovf.delete(); got_e.delete();
    send(16'd20, 16'd5, 1'b0);
    chk("t6_not_yet", out_valid, 0);
    tick();
    chk("t6_post_valid", out_valid, 1);
    chk("t6_post_result", out_result, 15);
    drain();
    chk("t6_n", got_res.size(), 1);

    // Randomized traffic with random back-pressure and clears
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(3) != 0);
      in_a       = ($urandom_range(2) == 0) ? EDGE[$urandom_range(8)] : 16'($urandom);
      in_b       = ($urandom_range(2) == 0) ? EDGE[$urandom_range(8)] : 16'($urandom);
      in_sat_en  = 1'($urandom);
      out_ready  = ($urandom_range(2) != 0);
      clr_sticky = ($urandom_range(15) == 0);
      tick();
    end
    in_valid = 1'b0;
    clr_sticky = 1'b0;
    out_ready = 1'b1;
    drain();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
